// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use bubbles, divider occupancy stalls and taken-branch flushes for ID/EXE/MEM.
module hazard_stall_controller #(
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rsA,
  input  logic [4:0] id_rsB,
  input  logic       id_is_jalr,
  input  logic       id_is_mul,
  input  logic [4:0] exe_rd,
  input  logic       exe_wr_en,
  input  logic [1:0] exe_sel_data,
  input  logic       exe_is_div,
  input  logic       exe_branch_taken,
  input  logic       div_done,
  output logic       if_stall,
  output logic       id_stall,
  output logic       id_flush,
  output logic       exe_flush,
  output logic       exe_stall,
  output logic       mem_flush,
  output logic       div_start,
  output logic       div_timeout,
  output logic       busy
);
  typedef enum logic {IDLE, DIV_BUSY} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             luse, last;
  assign luse = exe_wr_en && exe_sel_data == 2'd3 && exe_rd != 5'd0 &&
                ((id_is_jalr && id_rsA == exe_rd) ||
                 (id_is_mul && (id_rsA == exe_rd || id_rsB == exe_rd)));
  assign last = cnt_q == CNT_W'(DIV_CYCLES - 1);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    exe_flush   = 1'b0;
    exe_stall   = 1'b0;
    mem_flush   = 1'b0;
    div_start   = 1'b0;
    busy        = 1'b0;
    div_timeout = 1'b0;
    if (!rst) begin
      div_timeout = to_q;
      if (state_q == IDLE) begin
        if (exe_branch_taken) begin
          id_flush  = 1'b1;
          exe_flush = 1'b1;
        end else if (exe_is_div) begin
          div_start = 1'b1;
          {if_stall, id_stall, exe_stall, mem_flush} = 4'hf;
          cnt_d     = '0;
          state_d   = DIV_BUSY;
        end else if (luse) begin
          {if_stall, id_stall, exe_flush} = 3'b111;
        end
      end else begin
        busy = 1'b1;
        // a done pulse on the last counted cycle still counts as success
        if (div_done || last) begin
          state_d = IDLE;
          to_d    = to_q | ~div_done;
        end else begin
          {if_stall, id_stall, exe_stall, mem_flush} = 4'hf;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: table vectors plus divide/timeout/reset sequences, checked through an expectation queue.
module tb_hazard_stall_controller;
  localparam logic [8:0] IFS = 9'h100, IDS = 9'h080, IDF = 9'h040, EXF = 9'h020, EXS = 9'h010,
                         MEMF = 9'h008, DST = 9'h004, DTO = 9'h002, BSY = 9'h001;
  localparam logic [8:0] LU = IFS | IDS | EXF, BR = IDF | EXF, DV = IFS | IDS | EXS | MEMF;
  typedef struct {
    logic       rst;
    logic [4:0] rsA, rsB;
    logic       jalr, mul;
    logic [4:0] rd;
    logic       wr;
    logic [1:0] sel;
    logic       div, br, done;
    logic [8:0] exp;
    string      name;
  } vec_t;
  logic clk = 1'b0, rst;
  logic [4:0] id_rsA, id_rsB, exe_rd;
  logic id_is_jalr, id_is_mul, exe_wr_en, exe_is_div, exe_branch_taken, div_done;
  logic [1:0] exe_sel_data;
  logic if_stall, id_stall, id_flush, exe_flush, exe_stall, mem_flush, div_start, div_timeout, busy;
  logic [8:0] exp_q[$];
  string nm_q[$];
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[13];
  vec_t cur;
  hazard_stall_controller #(.DIV_CYCLES(34), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .id_rsA(id_rsA), .id_rsB(id_rsB), .id_is_jalr(id_is_jalr),
    .id_is_mul(id_is_mul), .exe_rd(exe_rd), .exe_wr_en(exe_wr_en), .exe_sel_data(exe_sel_data),
    .exe_is_div(exe_is_div), .exe_branch_taken(exe_branch_taken), .div_done(div_done),
    .if_stall(if_stall), .id_stall(id_stall), .id_flush(id_flush), .exe_flush(exe_flush),
    .exe_stall(exe_stall), .mem_flush(mem_flush), .div_start(div_start),
    .div_timeout(div_timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic j, logic m, logic [4:0] d,
                              logic w, logic [1:0] s, logic dv, logic br, logic dn, logic [8:0] e, string n);
    vec_t v;
    v.rst = r; v.rsA = a; v.rsB = b; v.jalr = j; v.mul = m; v.rd = d; v.wr = w; v.sel = s;
    v.div = dv; v.br = br; v.done = dn; v.exp = e; v.name = n;
    return v;
  endfunction
  task automatic step(input vec_t v);
    logic [8:0] got, want;
    string nm;
    @(posedge clk);
    #1;
    rst = v.rst; id_rsA = v.rsA; id_rsB = v.rsB; id_is_jalr = v.jalr; id_is_mul = v.mul;
    exe_rd = v.rd; exe_wr_en = v.wr; exe_sel_data = v.sel; exe_is_div = v.div;
    exe_branch_taken = v.br; div_done = v.done;
    exp_q.push_back(v.exp);
    nm_q.push_back(v.name);
    @(negedge clk);
    got  = {if_stall, id_stall, id_flush, exe_flush, exe_stall, mem_flush, div_start, div_timeout, busy};
    want = exp_q.pop_front();
    nm   = nm_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (if id idf exf exs memf dst dto busy)", nm, got, want);
    end
  endtask
  initial begin
    cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    tbl[0]  = mk(1, 5, 0, 1, 0, 5, 1, 3, 0, 0, 0, 0,   "rst_gates_luse");
    tbl[1]  = mk(0, 5, 0, 1, 0, 5, 1, 3, 0, 0, 0, LU,  "jalr_luse");
    tbl[2]  = mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0,   "jalr_after_bubble");
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0,   "jalr_x0");
    tbl[4]  = mk(0, 1, 7, 0, 1, 7, 1, 3, 0, 0, 0, LU,  "mul_rsB_luse");
    tbl[5]  = mk(0, 1, 7, 0, 0, 7, 1, 3, 0, 0, 0, 0,   "rsB_no_mul");
    tbl[6]  = mk(0, 7, 1, 0, 1, 7, 0, 3, 0, 0, 0, 0,   "mul_no_wr");
    tbl[7]  = mk(0, 7, 1, 0, 1, 7, 1, 2, 0, 0, 0, 0,   "mul_not_load");
    tbl[8]  = mk(0, 5, 0, 1, 0, 5, 1, 3, 0, 1, 0, BR,  "branch_over_luse");
    tbl[9]  = mk(0, 6, 5, 1, 0, 5, 1, 3, 0, 0, 0, 0,   "jalr_rsB_only");
    tbl[10] = mk(0, 9, 2, 0, 1, 9, 1, 3, 0, 0, 0, LU,  "mul_rsA_luse");
    tbl[11] = mk(0, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0, BR,  "branch_over_div");
    tbl[12] = mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,   "no_busy_after_branch");
    for (int i = 0; i < 13; i++) step(tbl[i]);
    // normal divide: done in the 10th busy cycle; div/branch/luse held high while busy
    cur = mk(0, 4, 4, 0, 1, 4, 1, 0, 1, 0, 0, DV | DST, "div_start");
    step(cur);
    cur.sel = 3;
    for (int k = 1; k <= 9; k++) begin
      cur.br = (k == 3); cur.exp = DV | BSY; cur.name = $sformatf("div_busy%0d", k);
      step(cur);
    end
    cur.done = 1; cur.exp = BSY; cur.name = "div_done_release";
    step(cur);
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "div_back_idle");
    step(cur);
    // done in the very first busy cycle
    cur.div = 1; cur.exp = DV | DST; cur.name = "div1_start"; step(cur);
    cur.div = 0; cur.done = 1; cur.exp = BSY; cur.name = "div1_done"; step(cur);
    cur.done = 0; cur.exp = 0; cur.name = "div1_idle"; step(cur);
    // timeout: release in busy cycle 34, sticky flag afterwards
    cur.div = 1; cur.exp = DV | DST; cur.name = "to_start"; step(cur);
    cur.div = 0;
    for (int k = 1; k <= 33; k++) begin
      cur.exp = DV | BSY; cur.name = $sformatf("to_busy%0d", k);
      step(cur);
    end
    cur.exp = BSY; cur.name = "to_release"; step(cur);
    cur.exp = DTO; cur.name = "to_sticky0"; step(cur);
    cur.done = 1; cur.exp = DTO; cur.name = "to_stray_done"; step(cur);
    cur = mk(0, 5, 0, 1, 0, 5, 1, 3, 0, 0, 0, LU | DTO, "to_luse"); step(cur);
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DTO, "to_sticky1"); step(cur);
    cur.rst = 1; cur.exp = 0; cur.name = "to_rst"; step(cur);
    cur.rst = 0; cur.name = "to_cleared"; step(cur);
    // reset in busy cycle 5
    cur.div = 1; cur.exp = DV | DST; cur.name = "rd_start"; step(cur);
    cur.div = 0;
    for (int k = 1; k <= 4; k++) begin
      cur.exp = DV | BSY; cur.name = $sformatf("rd_busy%0d", k);
      step(cur);
    end
    cur.rst = 1; cur.exp = 0; cur.name = "rd_rst_high"; step(cur);
    cur.rst = 0; cur.name = "rd_after_rst"; step(cur);
    cur.done = 1; cur.name = "rd_late_done"; step(cur);
    cur.done = 0; cur.name = "rd_idle"; step(cur);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
